search_write_ctrl: RTL and testbench

Parametrised converter-search-and-report controller. It sweeps a candidate value X upward from START_VAL. For each value it runs one start/end-of-conversion handshake with an external converter, then samples that device's "ok" verdict. Each accepted X is written to a memory-mapped output device, after polling that device's status register for readiness. It collects up to NUM_RESULTS hits per run and re-arms on a start pulse instead of parking forever.

---
 rtl/search_write_ctrl.sv | 150 +++++++++++++++
 tb/tb_search_write_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/search_write_ctrl.sv
// search_write_ctrl: sweeps x upward through converter handshakes and writes each accepted x to a polled bus device.
// Optional POLL_TIMEOUT_EN bounds the status polling to POLL_LIMIT reads per write.
module search_write_ctrl #(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] START_VAL  = '0,
  parameter int              NUM_RESULTS = 1,
  parameter logic [15:0]     STATUS_ADDR = 16'h0ABC,
  parameter logic [15:0]     DATA_ADDR   = 16'h0ABD,
  parameter int              READY_BIT   = 5,
  parameter int              POLL_LIMIT  = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             done,
  output logic             fail,
  output logic [7:0]       found_cnt,
  output logic             soc,
  input  logic             eoc,
  output logic [WIDTH-1:0] x,
  input  logic             ok,
  output logic [15:0]      addr,
  inout  wire  [WIDTH-1:0] data,
  output logic             ior_,
  output logic             iow_
);
  typedef enum logic [3:0] {
    IDLE, CONV_REQ, CONV_WAIT, EVAL, POLL_RD, POLL_CHK, WR_SETUP, WR_STB, WR_END, DONE
  } state_t;
  if (NUM_RESULTS < 1 || NUM_RESULTS > 255 || POLL_LIMIT < 1 || POLL_LIMIT > 255 ||
      READY_BIT < 0 || READY_BIT >= WIDTH) begin : g_bad_param
    $error("search_write_ctrl: parameter out of range");
  end
  state_t           state_q;
  logic             soc_q, ior_q, iow_q, oe_q, done_q, fail_q, rdy_q;
  logic [15:0]      addr_q;
  logic [WIDTH-1:0] x_q;
  logic [7:0]       cnt_q;
`ifdef POLL_TIMEOUT_EN
  logic [7:0]       poll_q;
`endif
  wire              x_max = &x_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign found_cnt = cnt_q;
  assign soc       = soc_q;
  assign x         = x_q;
  assign addr      = addr_q;
  assign ior_      = ior_q;
  assign iow_      = iow_q;
  assign data      = oe_q ? x_q : 'z;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      soc_q   <= 1'b0;
      ior_q   <= 1'b1;
      iow_q   <= 1'b1;
      oe_q    <= 1'b0;
      addr_q  <= STATUS_ADDR;
      x_q     <= START_VAL;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      rdy_q   <= 1'b0;
`ifdef POLL_TIMEOUT_EN
      poll_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          state_q <= CONV_REQ;
          soc_q   <= 1'b1;
          x_q     <= START_VAL;
          cnt_q   <= '0;
          fail_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        CONV_REQ: if (!eoc) begin
          state_q <= CONV_WAIT;
          soc_q   <= 1'b0;
        end
        CONV_WAIT: if (eoc) state_q <= EVAL;
        EVAL: if (ok) begin
          state_q <= POLL_RD;
          addr_q  <= STATUS_ADDR;
          ior_q   <= 1'b0;
`ifdef POLL_TIMEOUT_EN
          poll_q  <= '0;
`endif
        end else if (!x_max) begin
          state_q <= CONV_REQ;
          soc_q   <= 1'b1;
          x_q     <= x_q + 1'b1;
        end else begin
          state_q <= DONE;
          done_q  <= 1'b1;
          fail_q  <= 1'b1;
        end
        // ready bit is captured on the edge that ends the read strobe
        POLL_RD: begin
          state_q <= POLL_CHK;
          ior_q   <= 1'b1;
          rdy_q   <= data[READY_BIT];
        end
        POLL_CHK: begin
`ifdef POLL_TIMEOUT_EN
          poll_q <= poll_q + 8'd1;
`endif
          if (rdy_q) begin
            state_q <= WR_SETUP;
            addr_q  <= DATA_ADDR;
            oe_q    <= 1'b1;
`ifdef POLL_TIMEOUT_EN
          end else if (poll_q + 8'd1 >= 8'(POLL_LIMIT)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            fail_q  <= 1'b1;
`endif
          end else begin
            state_q <= POLL_RD;
            ior_q   <= 1'b0;
          end
        end
        WR_SETUP: begin
          state_q <= WR_STB;
          iow_q   <= 1'b0;
        end
        WR_STB: begin
          state_q <= WR_END;
          iow_q   <= 1'b1;
        end
        WR_END: begin
          oe_q  <= 1'b0;
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q + 8'd1 == 8'(NUM_RESULTS) || x_max) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            fail_q  <= cnt_q + 8'd1 != 8'(NUM_RESULTS);
          end else begin
            state_q <= CONV_REQ;
            soc_q   <= 1'b1;
            x_q     <= x_q + 1'b1;
            addr_q  <= STATUS_ADDR;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_search_write_ctrl.sv
// tb_search_write_ctrl: scoreboard bench with converter and status-register models.
module tb_search_write_ctrl;
  typedef struct {
    bit         is_done;
    logic [7:0] v;
    bit         f;
    int         nconv;
    int         nrd;
  } exp_t;
  logic        clock = 0, reset = 1, start = 0, eoc = 1, ok = 0;
  logic        done, fail, soc, ior_, iow_;
  logic [7:0]  found_cnt, x, stat = 8'h00;
  logic [15:0] addr;
  wire  [7:0]  data;
  bit          hit [256];
  int          nbusy = 0, rdn = 0, cyc_left = 0;
  int          checks = 0, errors = 0, nconv = 0, nrd = 0;
  logic        soc_p = 0, done_p = 0;
  exp_t        q[$];

  search_write_ctrl #(.WIDTH(8), .NUM_RESULTS(3), .POLL_LIMIT(3)) dut (
    .clock(clock), .reset(reset), .start(start), .done(done), .fail(fail),
    .found_cnt(found_cnt), .soc(soc), .eoc(eoc), .x(x), .ok(ok), .addr(addr),
    .data(data), .ior_(ior_), .iow_(iow_)
  );

  always #5 clock = ~clock;
  assign data = !ior_ ? stat : 'z;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (data[g]);
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, a, e);
    end
  endtask

  always @(negedge clock) begin
    if (soc && eoc) begin
      eoc = 0;
      cyc_left = 2;
    end else if (!soc && !eoc) begin
      if (cyc_left == 0) begin
        ok = hit[x];
        eoc = 1;
      end else cyc_left--;
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (soc && !soc_p) nconv++;
      if (!ior_ || !iow_) chk("strobe_excl", {31'd0, ior_ | iow_}, 1);
      if (!ior_) begin
        nrd++;
        chk("rd_addr", {16'd0, addr}, 32'h0ABC);
        stat = (rdn < nbusy) ? 8'h00 : 8'h20;
        rdn++;
      end
      if (!iow_) begin
        rdn = 0;
        if (q.size() == 0 || q[0].is_done) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write data %0h", data);
        end else begin
          e = q.pop_front();
          chk("wr_data", {24'd0, data}, {24'd0, e.v});
          chk("wr_addr", {16'd0, addr}, 32'h0ABD);
        end
      end
      if (done && !done_p) begin
        if (q.size() == 0 || !q[0].is_done) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done queue %0d", q.size());
          if (q.size() != 0) void'(q.pop_front());
        end else begin
          e = q.pop_front();
          chk("done_fail", {31'd0, fail}, {31'd0, e.f});
          chk("found_cnt", {24'd0, found_cnt}, {24'd0, e.v});
          chk("conversions", nconv, e.nconv);
          chk("status_reads", nrd, e.nrd);
        end
        nconv = 0;
        nrd = 0;
      end
    end
    soc_p = soc;
    done_p = done;
  end

  task automatic setup(input int nb);
    foreach (hit[i]) hit[i] = 0;
    nbusy = nb;
    rdn = 0;
  endtask

  task automatic pulse_start();
    @(negedge clock) start = 1;
    @(negedge clock) start = 0;
  endtask

  task automatic push_wr(input logic [7:0] v);
    q.push_back('{0, v, 0, 0, 0});
  endtask

  task automatic push_done(input bit f, input logic [7:0] c, input int nc, input int nr);
    q.push_back('{1, c, f, nc, nr});
  endtask

  task automatic go(input string n, input bit mid, input logic [7:0] x_end);
    int t = 0;
    pulse_start();
    if (mid) begin
      repeat (10) @(negedge clock);
      start = 1;
      @(negedge clock) start = 0;
    end
    while (!done && t < 5000) begin
      @(negedge clock);
      t++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout done=%0b", n, done);
      q.delete();
    end
    chk({n, "_x_end"}, {24'd0, x}, {24'd0, x_end});
  endtask

  initial begin
    int t = 0;
    repeat (3) @(negedge clock);
    reset = 0;
    setup(0);
    pulse_start();
    while (soc && t < 20) begin
      @(negedge clock);
      t++;
    end
    reset = 1;
    @(posedge clock);
    #1;
    chk("rst_soc", {31'd0, soc}, 0);
    chk("rst_ior", {31'd0, ior_}, 1);
    chk("rst_iow", {31'd0, iow_}, 1);
    chk("rst_data_released", {24'd0, data}, 32'hFF);
    chk("rst_x", {24'd0, x}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_fail", {31'd0, fail}, 0);
    chk("rst_found", {24'd0, found_cnt}, 0);
    chk("rst_addr", {16'd0, addr}, 32'h0ABC);
    @(posedge clock);
    @(negedge clock) reset = 0;
    nconv = 0;
    nrd = 0;

    setup(0);
    hit[2] = 1; hit[7] = 1; hit[9] = 1;
    push_wr(2); push_wr(7); push_wr(9);
    push_done(0, 3, 10, 3);
    go("three_hits", 1, 9);

    setup(4);
    hit[5] = 1;
    push_wr(5);
    push_done(1, 1, 256, 5);
    go("busy_poll", 0, 255);

    setup(0);
    push_done(1, 0, 256, 0);
    go("no_hits", 0, 255);

    setup(0);
    hit[255] = 1;
    push_wr(255);
    push_done(1, 1, 256, 1);
    go("hit_at_max", 0, 255);

`ifdef POLL_TIMEOUT_EN
    setup(1000);
    hit[1] = 1;
    push_done(1, 0, 2, 3);
    go("poll_timeout", 0, 1);
`endif

    repeat (3) @(negedge clock);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
